// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Sits beside the forwarding unit and covers the hazards forwarding cannot
// resolve: load-use, operands of a branch resolved in ID, and reads of a
// multiply/divide unit that is still busy. It drives the PC and IF/ID write
// enables and the ID/EX bubble, squashes the fetched instruction on taken
// branches and jumps, sequences the mult/div unit with a down-counter, and
// keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   if_id_rs, if_id_rt            source registers of the instruction in ID
//   id_uses_rt                    ID instruction reads rt
//   id_branch, id_branch_taken    conditional branch in ID and its outcome
//   id_jump                       j/jal/jr in ID
//   id_md_start, id_md_read       mult/div and mfhi/mflo in ID
//   id_ex_dst/memread/regwrite    EX-stage writer (regwrite active-low)
//   ex_mem_dst/memread/regwrite   MEM-stage writer (regwrite active-low)
//   pc_we, if_id_we               write enables, low while stalled
//   id_ex_bubble                  load a NOP into ID/EX
//   if_id_flush                   squash the fetched instruction
//   md_go, md_busy, md_done       mult/div start pulse, in-progress, last busy cycle
//   stall_cnt                     saturating stall-cycle counter
module hazard_ctrl #(
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             id_md_start,
    input  logic             id_md_read,
    input  logic [4:0]       id_ex_dst,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic [4:0]       ex_mem_dst,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_regwrite,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             md_go,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] LAT4 = 4'(MD_LAT);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t  state, state_next;
    logic [3:0] cnt, cnt_next;

    logic ex_match, mem_match;
    logic lu, bx, bm, mr;
    logic stall;

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    // A writer matches when it actually writes (active-low), targets a
    // non-zero register, and that register is rs, or rt when ID reads rt.
    // Branches always compare both operands, so they always read rt.
    function automatic logic writer_match(input logic [4:0] dst,
                                          input logic       regwrite_n,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic       reads_rt);
        return !regwrite_n && (dst != 5'd0) &&
               ((dst == rs) || (reads_rt && (dst == rt)));
    endfunction

    always_comb begin
        ex_match  = writer_match(id_ex_dst, id_ex_regwrite, if_id_rs, if_id_rt,
                                 id_uses_rt | id_branch);
        mem_match = writer_match(ex_mem_dst, ex_mem_regwrite, if_id_rs, if_id_rt,
                                 id_uses_rt | id_branch);

        lu = id_ex_memread & ex_match;
        bx = id_branch & ex_match;
        bm = id_branch & ex_mem_memread & mem_match;
        mr = (id_md_read | id_md_start) & md_busy;

        stall = lu | bx | bm | mr;

        pc_we        = !stall;
        if_id_we     = !stall;
        id_ex_bubble = stall;
        // A stalled branch is re-evaluated next cycle, so no squash yet.
        if_id_flush  = !stall & (id_jump | (id_branch & id_branch_taken));
        md_go        = id_md_start & !stall;
    end

    assign md_busy = (cnt != 4'd0);
    assign md_done = (cnt == 4'd1);

    // Mult/div sequencer: next-state and counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (md_go) begin
                    cnt_next   = LAT4;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // md_go cannot fire here: a busy unit forces a stall.
                if (cnt != 4'd0)
                    cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
// The driver applies one vector per cycle and pushes its expected response;
// a monitor on the falling edge pops and compares against the DUT outputs.
// A second instance with CNT_W=4 shares the inputs and checks saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
    logic        id_uses_rt, id_branch, id_branch_taken, id_jump;
    logic        id_md_start, id_md_read;
    logic        id_ex_memread, id_ex_regwrite, ex_mem_memread, ex_mem_regwrite;

    logic        pc_we, if_id_we, id_ex_bubble, if_id_flush;
    logic        md_go, md_busy, md_done;
    logic [15:0] stall_cnt;

    logic        s_pc_we, s_if_id_we, s_id_ex_bubble, s_if_id_flush;
    logic        s_md_go, s_md_busy, s_md_done;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .id_ex_dst(id_ex_dst), .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
        .ex_mem_dst(ex_mem_dst), .ex_mem_memread(ex_mem_memread), .ex_mem_regwrite(ex_mem_regwrite),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .md_go(md_go), .md_busy(md_busy),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MD_LAT(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .id_ex_dst(id_ex_dst), .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
        .ex_mem_dst(ex_mem_dst), .ex_mem_memread(ex_mem_memread), .ex_mem_regwrite(ex_mem_regwrite),
        .pc_we(s_pc_we), .if_id_we(s_if_id_we), .id_ex_bubble(s_id_ex_bubble),
        .if_id_flush(s_if_id_flush), .md_go(s_md_go), .md_busy(s_md_busy),
        .md_done(s_md_done), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        int          id;
        logic        stall;
        logic        flush;
        logic        go;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [3:0]  scnt;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int vec_n  = 0;

    // Stall-count models for both instances (16-bit and 4-bit saturating).
    logic [15:0] m_cnt  = 16'd0;
    logic [3:0]  m_scnt = 4'd0;

    task automatic chk(input string name, input int id,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, id, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh response every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_we",        e.id, 16'(pc_we),        16'(!e.stall));
            chk("if_id_we",     e.id, 16'(if_id_we),     16'(!e.stall));
            chk("id_ex_bubble", e.id, 16'(id_ex_bubble), 16'(e.stall));
            chk("if_id_flush",  e.id, 16'(if_id_flush),  16'(e.flush));
            chk("md_go",        e.id, 16'(md_go),        16'(e.go));
            chk("md_busy",      e.id, 16'(md_busy),      16'(e.busy));
            chk("md_done",      e.id, 16'(md_done),      16'(e.done));
            chk("stall_cnt",    e.id, stall_cnt,         e.cnt);
            chk("sat_stall_cnt",e.id, 16'(s_stall_cnt),  16'(e.scnt));
        end
    end

    task automatic idle_in();
        if_id_rs = 5'd0;  if_id_rt = 5'd0;  id_uses_rt = 1'b0;
        id_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
        id_md_start = 1'b0; id_md_read = 1'b0;
        id_ex_dst = 5'd0; id_ex_memread = 1'b0; id_ex_regwrite = 1'b1;
        ex_mem_dst = 5'd0; ex_mem_memread = 1'b0; ex_mem_regwrite = 1'b1;
    endtask

    // Push the expected response for the inputs currently applied, then
    // advance one clock and update the counter models.
    task automatic step(input logic e_stall, input logic e_flush,
                        input logic e_go, input logic e_busy, input logic e_done);
        exp_t e;
        e.id = vec_n; e.stall = e_stall; e.flush = e_flush; e.go = e_go;
        e.busy = e_busy; e.done = e_done; e.cnt = m_cnt; e.scnt = m_scnt;
        exp_q.push_back(e);
        vec_n++;
        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt  = 16'd0;
            m_scnt = 4'd0;
        end else if (e_stall) begin
            if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 16'd1;
            if (m_scnt != 4'hF)     m_scnt = m_scnt + 4'd1;
        end
    endtask

    // ALU op in EX writing dst (no load).
    task automatic ex_alu(input logic [4:0] d);
        id_ex_dst = d; id_ex_memread = 1'b0; id_ex_regwrite = 1'b0;
    endtask

    task automatic ex_load(input logic [4:0] d);
        id_ex_dst = d; id_ex_memread = 1'b1; id_ex_regwrite = 1'b0;
    endtask

    task automatic mem_load(input logic [4:0] d);
        ex_mem_dst = d; ex_mem_memread = 1'b1; ex_mem_regwrite = 1'b0;
    endtask

    task automatic mem_alu(input logic [4:0] d);
        ex_mem_dst = d; ex_mem_memread = 1'b0; ex_mem_regwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;

        // Reset state, still in reset.
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);

        // Load-use: lw $5 in EX, add rs=5 in ID -> one stall.
        idle_in(); ex_load(5'd5); if_id_rs = 5'd5;
        step(1, 0, 0, 0, 0);
        idle_in(); mem_load(5'd5); if_id_rs = 5'd5;
        step(0, 0, 0, 0, 0);

        // Load then taken beq rs=7: bx (with lu), then bm, then flush.
        idle_in(); ex_load(5'd7); if_id_rs = 5'd7; id_branch = 1'b1; id_branch_taken = 1'b1;
        step(1, 0, 0, 0, 0);
        idle_in(); mem_load(5'd7); if_id_rs = 5'd7; id_branch = 1'b1; id_branch_taken = 1'b1;
        step(1, 0, 0, 0, 0);
        idle_in(); if_id_rs = 5'd7; id_branch = 1'b1; id_branch_taken = 1'b1;
        step(0, 1, 0, 0, 0);

        // ALU op then not-taken beq on rt: one stall, forwarding covers MEM.
        idle_in(); ex_alu(5'd9); if_id_rs = 5'd1; if_id_rt = 5'd9; id_branch = 1'b1;
        step(1, 0, 0, 0, 0);
        idle_in(); mem_alu(5'd9); if_id_rs = 5'd1; if_id_rt = 5'd9; id_branch = 1'b1;
        step(0, 0, 0, 0, 0);

        // rt only matters when the instruction reads it.
        idle_in(); ex_load(5'd6); if_id_rt = 5'd6;
        step(0, 0, 0, 0, 0);
        idle_in(); ex_load(5'd6); if_id_rt = 5'd6; id_uses_rt = 1'b1;
        step(1, 0, 0, 0, 0);

        // Register 0 and a non-writing EX never stall.
        idle_in(); ex_load(5'd0); if_id_rs = 5'd0;
        step(0, 0, 0, 0, 0);
        idle_in(); id_ex_dst = 5'd5; id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; if_id_rs = 5'd5;
        step(0, 0, 0, 0, 0);

        // Jump flushes; a stalled jump does not.
        idle_in(); id_jump = 1'b1;
        step(0, 1, 0, 0, 0);
        idle_in(); id_jump = 1'b1; ex_load(5'd3); if_id_rs = 5'd3;
        step(1, 0, 0, 0, 0);

        // Mult at T, mflo waits T+1..T+8, proceeds at T+9.
        idle_in(); id_md_start = 1'b1;
        step(0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            idle_in(); id_md_read = 1'b1;
            step(1, 0, 0, 1, (i == 8));
        end
        idle_in(); id_md_read = 1'b1;
        step(0, 0, 0, 0, 0);

        // Reset mid-operation at T+3; the waiting mflo proceeds immediately.
        idle_in(); id_md_start = 1'b1;
        step(0, 0, 1, 0, 0);
        idle_in(); id_md_read = 1'b1;
        step(1, 0, 0, 1, 0);
        idle_in(); id_md_start = 1'b1;           // second mult while busy: stalled, no go
        step(1, 0, 0, 1, 0);
        idle_in(); id_md_read = 1'b1; rst = 1'b1;
        step(1, 0, 0, 1, 0);
        rst = 1'b0;
        idle_in(); id_md_read = 1'b1;
        step(0, 0, 0, 0, 0);

        // Hold a load-use stall for 20 cycles: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            idle_in(); ex_load(5'd4); if_id_rs = 5'd4;
            step(1, 0, 0, 0, 0);
        end
        idle_in();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the forwarding unit and drives the PC, IF/ID and ID/EX enables.
- Detects hazards that forwarding cannot cover: load-use, branch-in-ID operand hazards, and reads of a busy multi-cycle multiply/divide unit.
- Issues stalls, bubbles and flushes, and sequences the multiply/divide unit with an internal busy counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MD_LAT, 8, multiply/divide latency in cycles (legal range 2..15)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_id_rs  in  5  rs of the instruction in ID
if_id_rt  in  5  rt of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID holds a conditional branch (compares rs and rt in ID)
id_branch_taken  in  1  branch comparison result in ID
id_jump  in  1  ID holds j/jal/jr
id_md_start  in  1  ID holds mult/div
id_md_read  in  1  ID holds mfhi/mflo
id_ex_dst  in  5  destination register in EX
id_ex_memread  in  1  EX holds a load
id_ex_regwrite  in  1  EX register write, active-low (0 = writes)
ex_mem_dst  in  5  destination register in MEM
ex_mem_memread  in  1  MEM holds a load
ex_mem_regwrite  in  1  MEM register write, active-low
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable
id_ex_bubble  out  1  load NOP into ID/EX
if_id_flush  out  1  clear IF/ID (squash fetched instruction)
md_go  out  1  one-cycle start pulse to the mult/div unit
md_busy  out  1  mult/div unit in progress
md_done  out  1  last busy cycle; HI/LO written at the end of it
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Register 0 never creates a hazard. A match needs writer regwrite==0, dst!=0, and dst equal to rs (or to rt when id_uses_rt or id_branch).
- Hazard terms, all combinational, evaluated every cycle:
  - lu: load-use. id_ex_memread and an EX match.
  - bx: id_branch and an EX match with EX regwrite active (covers ALU and load in EX).
  - bm: id_branch and ex_mem_memread and a MEM match.
  - mr: (id_md_read or id_md_start) and md_busy.
- stall = lu | bx | bm | mr.
  - While stall: pc_we=0, if_id_we=0, id_ex_bubble=1.
  - Otherwise: pc_we=1, if_id_we=1, id_ex_bubble=0.
- Stall sequences resolve naturally as the pipeline advances:
  - Load then dependent branch: 2 stall cycles (bx, then bm).
  - ALU op then dependent branch: 1 stall cycle; EX/MEM forwarding then supplies the operand.
- if_id_flush = !stall & (id_jump | (id_branch & id_branch_taken)). Stall takes priority; the branch is re-evaluated next cycle.
- Multiply/divide sequencer: registered state IDLE/BUSY with a 4-bit down-counter cnt.
  - md_busy = (cnt != 0).
  - md_go = id_md_start & !stall. md_go cannot fire while busy because mr forces stall.
  - On md_go: cnt <= MD_LAT at the clock edge.
  - Else if cnt != 0: cnt <= cnt - 1.
  - md_done = (cnt == 1).
  - With md_go in cycle T: busy in cycles T+1..T+MD_LAT; a dependent mfhi/mflo proceeds at T+MD_LAT+1.
- stall_cnt: increments at each clock edge where stall=1; holds at all-ones (saturates).
- Reset, effective at the clock edge, including mid-operation:
  - cnt=0, stall_cnt=0, so md_busy=0 and md_done=0.
  - An in-flight mult/div is abandoned.
- Outputs during the rst=1 cycle: rst does not gate the combinational terms. Because md_busy is 0 after reset, outputs then follow the inputs only.
- Latency: stall, flush and enable outputs are combinational, with zero cycles from input to output. md_busy, md_done and stall_cnt are derived from registers.

Test Plan:
- Load-use: lw $5 in EX (memread=1, regwrite=0, dst=5), ID add with rs=5 -> one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt 0->1.
- Load then beq: EX=lw dst=7, ID beq rs=7 -> 2 stall cycles (bx, then bm with MEM=lw dst=7); no if_id_flush until the third cycle; taken branch -> if_id_flush=1 that cycle.
- Zero register and inactive write: EX dst=0 load with rs=0, then EX dst=5 with regwrite=1 and rs=5 -> no stall, stall_cnt unchanged.
- Mult/div: MD_LAT=8; mult in ID at T -> md_go at T; md_busy T+1..T+8; md_done at T+8; mflo in ID from T+1 -> stalled 8 cycles, advances at T+9; stall_cnt=8.
- Reset mid-op: rst=1 at T+3 of a busy mult/div -> next cycle md_busy=0, stall_cnt=0; a waiting mflo proceeds immediately.
- Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt=15 and holds at 15.
